eth_tx_arbiter: RTL and testbench
=================================

Name: eth_tx_arbiter

Overview:
- Round-robin transmit scheduler that shares one eth_generator between NUM_REQ byte-stream payload sources.
- Grants one requester per frame and pulses the generator's start.
- Muxes the granted source's payload bytes, done and readclk between requester and generator.
- Holds the grant until the generator reports end of inter-frame gap; enforces a maximum payload length by forcing in_done.

Parameters:
NUM_REQ, 2, number of payload requesters (1..8)
MAX_PAYLOAD, 1500, payload byte limit per frame; reaching it forces end of payload
WDOG_CYCLES, 65535, watchdog limit in cycles from gen_start to gen_done (used only with ETH_TX_ARB_WDOG_EN)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
req  input  NUM_REQ  per-source frame request, level; held until granted
req_inclk  input  NUM_REQ  per-source payload byte strobe
req_in  input  NUM_REQ*8  per-source payload bytes; source i occupies bits [8i+:8]
req_done  input  NUM_REQ  per-source end-of-payload flag
req_readclk  output  NUM_REQ  per-source read request (upstream_readclk routed to the granted source)
grant  output  NUM_REQ  one-hot current owner; 0 when idle
busy  output  1  high while a frame is in progress
gen_start  output  1  one-cycle start pulse to eth_generator
gen_inclk  output  1  payload strobe to generator
gen_in  output  8  payload byte to generator
gen_in_done  output  1  end-of-payload to generator
gen_upstream_readclk  input  1  generator's payload read request
gen_done  input  1  generator end-of-gap pulse
trunc  output  1  one-cycle pulse when a payload is truncated at MAX_PAYLOAD
wdog_err  output  1  one-cycle watchdog abort pulse (tied 0 without ETH_TX_ARB_WDOG_EN)

Behaviour:
- Reset values: grant=0, busy=0, gen_start=0, trunc=0, wdog_err=0, RR pointer=NUM_REQ-1, byte_cnt=0, state IDLE. rst mid-frame drops the grant immediately. The generator shares the same rst.
- States: IDLE, FRAME, DRAIN.
- IDLE: if any req bit is set, choose the first set index scanning upward from pointer+1 (modulo NUM_REQ). On the next edge, register grant (one-hot), set pointer to that index, assert gen_start for exactly that cycle, clear byte_cnt, and enter FRAME. Request-to-gen_start latency is 1 cycle.
- FRAME:
  - gen_inclk = req_inclk[g] and gen_in = req_in[8g+:8]; ungranted strobes are ignored.
  - req_readclk[g] = gen_upstream_readclk; all other req_readclk bits are 0. These paths are combinational.
  - byte_cnt increments on each granted req_inclk and saturates at MAX_PAYLOAD.
  - gen_in_done = req_done[g] OR (byte_cnt == MAX_PAYLOAD).
  - On the first cycle gen_in_done and gen_upstream_readclk are both high, enter DRAIN. If the truncation term caused it and req_done[g]=0, pulse trunc on that transition.
- DRAIN: forwarding is gated off (gen_inclk=0, req_readclk=0, gen_in_done=0) while the generator sends CRC and gap. On gen_done, clear grant and return to IDLE. Arbitration may occur on the following edge (no back-to-back gen_start closer than 1 IDLE cycle).
- gen_done in FRAME (early/unexpected): treated as frame end; return to IDLE.
- busy = (state != IDLE).
- req deassertion after grant has no effect; req for the owner held at frame end is re-arbitrated fairly (owner becomes lowest priority).
- byte_cnt width = clog2(MAX_PAYLOAD+1).

Optional Feature:
- Macro: ETH_TX_ARB_WDOG_EN.
- With it: a cycle counter starts at gen_start and clears on gen_done. When it reaches WDOG_CYCLES in FRAME or DRAIN:
  - pulse wdog_err;
  - pulse gen_start-free abort (grant cleared);
  - return to IDLE;
  - advance the pointer past the stalled owner.
- Without it: no counter; wdog_err is constant 0 and frames wait indefinitely for gen_done.

Decomposition:
- Shared networking package/include: BYTE_LEN, ETH_MAX_PAYLOAD_LEN default (1500), clog2.
- One natural sub-module: rr_arbiter (request vector + pointer -> one-hot grant, combinational priority scan). It is reusable for other shared resources.

Test Plan:
- Single source: req=01, 10-byte payload with req_done on byte 10 -> gen_start 1 cycle after req, grant=01; exactly 10 gen_inclk bytes pass unchanged; DRAIN until gen_done; grant=00 the cycle after gen_done.
- Simultaneous req=11 after reset -> source 0 granted first, source 1 next frame; with both held continuously, grants alternate 01,10,01,10.
- Truncation: MAX_PAYLOAD=8, source streams 20 bytes with no req_done -> gen_in_done asserted at byte_cnt=8; trunc pulses once; no further bytes are forwarded.
- Isolation: while grant=01, source 1 toggles req_inclk with data 0xAA -> gen_inclk/gen_in are unaffected; req_readclk[1] stays 0.
- Reset mid-FRAME after 3 bytes -> next cycle grant=0, busy=0, gen_start=0; a fresh req after reset rearbitrates from pointer=NUM_REQ-1.
- ETH_TX_ARB_WDOG_EN, WDOG_CYCLES=50, gen_done never asserted -> wdog_err pulses 50 cycles after gen_start; state IDLE; pending other requester granted next.

Source files
------------

// File: rtl/eth_tx_arbiter_pkg.sv
// eth_tx_arbiter_pkg: shared networking constants, transmit arbiter state type and clog2 helper.
package eth_tx_arbiter_pkg;
   localparam int BYTE_LEN = 8;
   localparam int ETH_MAX_PAYLOAD_LEN = 1500;
   typedef enum logic [1:0] {IDLE, FRAME, DRAIN} arb_state_e;
   function automatic int clog2(input int v);
      int r;
      for (r = 0; (1 << r) < v; r++) ;
      return r;
   endfunction
endpackage

// File: rtl/eth_tx_arbiter_rr.sv
// rr_arbiter: combinational round-robin scan; first set request strictly after ptr_i wins.
module rr_arbiter import eth_tx_arbiter_pkg::*; #(
   parameter int N = 2,
   localparam int PW = (N > 1) ? clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  grant_o,
   output logic [PW-1:0] idx_o,
   output logic          any_o
);
   // Scan from the farthest candidate down so the nearest one after ptr_i is written last.
   always_comb begin
      grant_o = '0;
      idx_o = ptr_i;
      any_o = |req_i;
      for (int k = N; k >= 1; k--) begin
         if (req_i[(int'(ptr_i) + k) % N]) begin
            grant_o = N'(1) << ((int'(ptr_i) + k) % N);
            idx_o = PW'((int'(ptr_i) + k) % N);
         end
      end
   end
endmodule

// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: round-robin frame scheduler sharing one eth_generator between NUM_REQ payload sources.
// Define ETH_TX_ARB_WDOG_EN to abort frames whose gen_done does not arrive within WDOG_CYCLES.
module eth_tx_arbiter import eth_tx_arbiter_pkg::*; #(
   parameter int NUM_REQ = 2,
   parameter int MAX_PAYLOAD = ETH_MAX_PAYLOAD_LEN,
   parameter int WDOG_CYCLES = 65535
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [NUM_REQ-1:0]    req_inclk,
   input  logic [NUM_REQ*8-1:0]  req_in,
   input  logic [NUM_REQ-1:0]    req_done,
   output logic [NUM_REQ-1:0]    req_readclk,
   output logic [NUM_REQ-1:0]    grant,
   output logic                  busy,
   output logic                  gen_start,
   output logic                  gen_inclk,
   output logic [7:0]            gen_in,
   output logic                  gen_in_done,
   input  logic                  gen_upstream_readclk,
   input  logic                  gen_done,
   output logic                  trunc,
   output logic                  wdog_err
);
   localparam int PW = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1;
   localparam int CW = clog2(MAX_PAYLOAD + 1);
   if (NUM_REQ < 1 || NUM_REQ > 8 || MAX_PAYLOAD < 1 || WDOG_CYCLES < 1) begin : g_bad_cfg
      $error("eth_tx_arbiter: parameter out of range");
   end
   arb_state_e state_q;
   logic [NUM_REQ-1:0] grant_q, arb_grant;
   logic [PW-1:0] ptr_q, arb_idx;
   logic [CW-1:0] byte_cnt_q;
   logic gen_start_q, trunc_q, wdog_err_q, arb_any, in_frame, at_limit, abort;
   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .req_i(req), .ptr_i(ptr_q), .grant_o(arb_grant), .idx_o(arb_idx), .any_o(arb_any)
   );
   // ptr_q doubles as the owner index while a frame is in progress.
   assign in_frame = state_q == FRAME;
   assign at_limit = byte_cnt_q == CW'(MAX_PAYLOAD);
   assign gen_inclk = in_frame && req_inclk[ptr_q] && !at_limit;
   assign gen_in = req_in[ptr_q*BYTE_LEN +: BYTE_LEN];
   assign gen_in_done = in_frame && (req_done[ptr_q] || at_limit);
   assign req_readclk = in_frame ? NUM_REQ'(gen_upstream_readclk) << ptr_q : '0;
   assign grant = grant_q;
   assign busy = state_q != IDLE;
   assign gen_start = gen_start_q;
   assign trunc = trunc_q;
   assign wdog_err = wdog_err_q;
`ifdef ETH_TX_ARB_WDOG_EN
   localparam int WW = clog2(WDOG_CYCLES + 1);
   logic [WW-1:0] wdog_q;
   always_ff @(posedge clk)
      wdog_q <= (rst || state_q == IDLE) ? '0 : wdog_q + 1'b1;
   assign abort = !gen_done && wdog_q == WW'(WDOG_CYCLES - 1);
`else
   assign abort = 1'b0;
`endif
   always_ff @(posedge clk) begin
      gen_start_q <= 1'b0;
      trunc_q <= 1'b0;
      wdog_err_q <= 1'b0;
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         ptr_q <= PW'(NUM_REQ - 1);
         byte_cnt_q <= '0;
      end else begin
         if (gen_inclk) byte_cnt_q <= byte_cnt_q + 1'b1;
         case (state_q)
            IDLE: if (arb_any) begin
               state_q <= FRAME;
               grant_q <= arb_grant;
               ptr_q <= arb_idx;
               gen_start_q <= 1'b1;
               byte_cnt_q <= '0;
            end
            FRAME, DRAIN: if (gen_done || abort) begin
               state_q <= IDLE;
               grant_q <= '0;
               wdog_err_q <= abort;
            end else if (in_frame && gen_in_done && gen_upstream_readclk) begin
               state_q <= DRAIN;
               trunc_q <= at_limit && !req_done[ptr_q];
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb_eth_tx_arbiter: randomized scoreboard bench; a monitor checks forwarded bytes, grants and pulses.
module tb_eth_tx_arbiter;
   localparam int N = 2, MAXP = 12, WD = 50;
   logic clk = 0, rst = 1;
   logic [N-1:0] req = '0, req_inclk = '0, req_done = '0, req_readclk, grant;
   logic [N*8-1:0] req_in = '0;
   logic busy, gen_start, gen_inclk, gen_in_done, trunc, wdog_err;
   logic [7:0] gen_in;
   logic gen_upstream_readclk = 0, gen_done = 0;
   int tests = 0, fails = 0, trunc_exp = 0, trunc_seen = 0, wdog_exp = 0, wdog_seen = 0;
   int last = N - 1;
   logic [7:0] byte_q[$];
   logic [N-1:0] grant_q[$];
   always #5 clk = ~clk;
   eth_tx_arbiter #(.NUM_REQ(N), .MAX_PAYLOAD(MAXP), .WDOG_CYCLES(WD)) dut (
      .clk(clk), .rst(rst), .req(req), .req_inclk(req_inclk), .req_in(req_in), .req_done(req_done),
      .req_readclk(req_readclk), .grant(grant), .busy(busy), .gen_start(gen_start), .gen_inclk(gen_inclk),
      .gen_in(gen_in), .gen_in_done(gen_in_done), .gen_upstream_readclk(gen_upstream_readclk),
      .gen_done(gen_done), .trunc(trunc), .wdog_err(wdog_err)
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   function automatic logic [N-1:0] onehot(input int o);
      return N'(1) << o;
   endfunction
   // Round-robin rule: first requester strictly after the previous owner, wrapping.
   function automatic int pick(input logic [N-1:0] rq, input int prev);
      for (int k = 1; k <= N; k++) if (rq[(prev + k) % N]) return (prev + k) % N;
      return -1;
   endfunction
   always @(negedge clk) begin
      if (gen_inclk) begin
         if (byte_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_byte: got %0h expected none", gen_in);
         end else chk("payload_byte", gen_in, byte_q.pop_front());
      end
      if (gen_start) begin
         if (grant_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_start: grant %0h expected no start", grant);
         end else chk("grant", grant, grant_q.pop_front());
      end
      if (trunc) trunc_seen++;
      if (wdog_err) wdog_seen++;
   end
   task automatic wait_start(output bit ok, output int cyc);
      ok = 0;
      for (cyc = 0; cyc < 10 && !ok; cyc++) begin
         @(posedge clk); #1;
         ok = gen_start;
      end
      if (!ok) begin
         tests++; fails++;
         $display("FAIL gen_start_timeout: none within 10 cycles expected 1");
      end
   endtask
   task automatic frame(input logic [N-1:0] rq, input int n, input bit noise, input bit drop, input bit early);
      int o, cnt, cyc, i;
      bit ok, live, ended, done, rc, stb;
      logic [7:0] d;
      req = rq;
      o = pick(rq, last);
      grant_q.push_back(onehot(o));
      last = o;
      wait_start(ok, cyc);
      if (!ok) begin
         req = '0;
         return;
      end
      chk("start_latency", cyc, 1);
      if (drop) req[o] = 1'b0;
      cnt = 0; i = 0; live = 1; ended = 0; done = 0;
      for (int c = 0; c < 200 && !ended && (live || i < n); c++) begin
         stb = i < n && $urandom_range(7) != 0;
         rc = $urandom_range(3) != 0;
         if (stb) begin
            d = 8'($urandom);
            req_in[o*8 +: 8] = d;
            i++;
            done = done || (i == n && n <= MAXP);
            if (live && cnt < MAXP) byte_q.push_back(d);
         end
         req_inclk[o] = stb;
         req_done[o] = done;
         gen_upstream_readclk = rc;
         for (int j = 0; j < N; j++) if (j != o) begin
            req_inclk[j] = noise && $urandom_range(1) == 1;
            req_in[j*8 +: 8] = 8'hAA;
         end
         gen_done = early && live && i >= 3;
         #1;
         chk("readclk", req_readclk, (live && rc) ? onehot(o) : '0);
         chk("in_done", gen_in_done, live && (done || cnt == MAXP));
         @(posedge clk); #1;
         if (gen_done) begin
            ended = 1;
            live = 0;
         end else if (live && rc && (done || cnt == MAXP)) begin
            live = 0;
            if (!done) trunc_exp++;
         end
         if (stb && cnt < MAXP) cnt++;
      end
      req_inclk = '0; req_done = '0; gen_upstream_readclk = 0; gen_done = 0;
      if (live) begin
         tests++; fails++;
         $display("FAIL drain_timeout: still in frame expected drain");
      end
      if (!ended) begin
         repeat ($urandom_range(2)) begin
            chk("busy_drain", busy, 1);
            @(posedge clk); #1;
         end
         gen_done = 1;
         @(posedge clk); #1;
         gen_done = 0;
      end
      chk("grant_clear", grant, 0);
      chk("idle", busy, 0);
      req = '0;
   endtask
   initial begin
      bit ok;
      int cyc, o, k;
      logic [7:0] d;
      #200000;
      $display("FAIL global_timeout: simulation did not finish expected finish");
      $fatal(1);
   end
   initial begin
      bit ok;
      int cyc, o, k;
      logic [7:0] d;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      chk("rst_grant", grant, 0);
      chk("rst_busy", busy, 0);
      chk("rst_start", gen_start, 0);
      chk("rst_trunc", trunc, 0);
      chk("rst_wdog", wdog_err, 0);
      frame(2'b01, 10, 0, 0, 0);
      repeat (4) frame(2'b11, 6, 1, 0, 0);
      frame(2'b01, 16, 1, 0, 0);
      req = 2'b01;
      o = pick(req, last);
      grant_q.push_back(onehot(o));
      last = o;
      wait_start(ok, cyc);
      for (int i = 0; i < 3; i++) begin
         d = 8'($urandom);
         req_in[o*8 +: 8] = d;
         req_inclk[o] = 1;
         byte_q.push_back(d);
         @(posedge clk); #1;
      end
      req_inclk = '0; req = '0; rst = 1;
      @(posedge clk); #1;
      rst = 0;
      last = N - 1;
      chk("midrst_grant", grant, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_start", gen_start, 0);
      frame(2'b11, 5, 0, 0, 0);
      frame(2'b11, 8, 1, 1, 1);
`ifdef ETH_TX_ARB_WDOG_EN
      req = 2'b11;
      o = pick(req, last);
      grant_q.push_back(onehot(o));
      last = o;
      wait_start(ok, cyc);
      k = 0;
      while (!wdog_err && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      wdog_exp++;
      chk("wdog_latency", k, WD);
      chk("wdog_grant", grant, 0);
      chk("wdog_idle", busy, 0);
      frame(2'b11, 4, 0, 0, 0);
`endif
      for (int f = 0; f < 20; f++)
         frame(N'($urandom_range(1, 3)), $urandom_range(1, 16), $urandom_range(1) == 1,
               $urandom_range(1) == 1, $urandom_range(7) == 0);
      repeat (4) @(posedge clk);
      #1;
      chk("bytes_left", byte_q.size(), 0);
      chk("grants_left", grant_q.size(), 0);
      chk("trunc_count", trunc_seen, trunc_exp);
      chk("wdog_count", wdog_seen, wdog_exp);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
